linescanner_frame_controller: RTL and testbench

LINESCANNER_FRAME_CONTROLLER -- requirements
Module: linescanner_frame_controller

---
 rtl/linescanner_pkg.sv | 9 +
 rtl/linescanner_line_timer.sv | 20 ++
 rtl/linescanner_frame_controller.sv | 136 +++++++++++++
 tb/tb_linescanner_frame_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/linescanner_pkg.sv
// linescanner_pkg: shared state encoding, counter width and default timing constants.
package linescanner_pkg;
    localparam int CNT_W = 16;
    localparam int DEF_PIXELS_PER_LINE = 1024;
    localparam int DEF_LINES_PER_FRAME = 512;
    localparam int DEF_LINE_PERIOD_CLKS = 4096;
    localparam int DEF_TIMEOUT_CLKS = 8192;
    typedef enum logic [2:0] {IDLE, ARM, ACTIVE, GAP, DONE} state_t;
endpackage

// File: rtl/linescanner_line_timer.sv
// linescanner_line_timer: saturating cycle counter with clear and a threshold compare.
module linescanner_line_timer
    import linescanner_pkg::*;
(
    input  logic             main_clock_source,
    input  logic             n_reset,
    input  logic             clear,
    input  logic             count,
    input  logic [CNT_W-1:0] threshold,
    output logic             reached
);
    logic [CNT_W-1:0] value;
    always_ff @(posedge main_clock_source) begin
        if (!n_reset || clear)
            value <= '0;
        else if (count && value != '1)
            value <= value + 1'b1;
    end
    assign reached = value >= threshold;
endmodule

// File: rtl/linescanner_frame_controller.sv
// linescanner_frame_controller: sequences arm/capture/gap per line across a frame.
// Optional ARM-dwell timeout enabled by defining LINESCANNER_TIMEOUT_EN.
module linescanner_frame_controller
    import linescanner_pkg::*;
#(
    parameter int PIXELS_PER_LINE  = DEF_PIXELS_PER_LINE,
    parameter int LINES_PER_FRAME  = DEF_LINES_PER_FRAME,
    parameter int LINE_PERIOD_CLKS = DEF_LINE_PERIOD_CLKS,
    parameter int TIMEOUT_CLKS     = DEF_TIMEOUT_CLKS
) (
    input  logic             main_clock_source,
    input  logic             n_reset,
    input  logic             start,
    input  logic             abort,
    input  logic             lval,
    output logic             scanner_enable,
    output logic             busy,
    output logic [CNT_W-1:0] line_index,
    output logic [CNT_W-1:0] pixel_count,
    output logic             line_done,
    output logic             frame_done,
    output logic             line_error,
    output logic             timeout_error
);
    localparam logic [CNT_W-1:0] PIX_EXP   = CNT_W'(PIXELS_PER_LINE);
    localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(LINES_PER_FRAME - 1);
    localparam logic [CNT_W-1:0] PERIOD_TH = CNT_W'(LINE_PERIOD_CLKS - 1);
    localparam logic [CNT_W-1:0] TMO_TH    = CNT_W'(TIMEOUT_CLKS - 1);

    state_t state, state_n;
    logic [CNT_W-1:0] line_index_n, pixel_count_n;
    logic line_done_n, frame_done_n, line_error_n, timer_hit;
`ifdef LINESCANNER_TIMEOUT_EN
    logic timeout_n;
`endif

    // One counter serves both the line period (GAP) and the ARM dwell limit.
    linescanner_line_timer u_timer (
        .main_clock_source(main_clock_source),
        .n_reset(n_reset),
        .clear(state_n == ARM && state != ARM),
        .count(state != IDLE),
        .threshold(state == ARM ? TMO_TH : PERIOD_TH),
        .reached(timer_hit)
    );

    always_comb begin
        state_n = state;
        line_index_n = line_index;
        pixel_count_n = pixel_count;
        line_done_n = 1'b0;
        frame_done_n = 1'b0;
        line_error_n = 1'b0;
`ifdef LINESCANNER_TIMEOUT_EN
        timeout_n = 1'b0;
`endif
        case (state)
            IDLE: if (start) begin
                state_n = ARM;
                line_index_n = '0;
                pixel_count_n = '0;
            end
            ARM: if (lval) begin
                state_n = ACTIVE;
                pixel_count_n = CNT_W'(1);
            end
`ifdef LINESCANNER_TIMEOUT_EN
            else if (timer_hit) begin
                state_n = IDLE;
                timeout_n = 1'b1;
            end
`endif
            ACTIVE: if (lval) begin
                pixel_count_n = pixel_count == '1 ? pixel_count : pixel_count + 1'b1;
            end else begin
                line_done_n = 1'b1;
                line_error_n = pixel_count != PIX_EXP;
                state_n = line_index == LAST_LINE ? DONE : GAP;
            end
            GAP: if (timer_hit) begin
                state_n = ARM;
                line_index_n = line_index + 1'b1;
            end
            DONE: begin
                state_n = IDLE;
                frame_done_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // Abort overrides every event above and leaves the counters untouched.
        if (abort && state != IDLE) begin
            state_n = IDLE;
            line_index_n = line_index;
            pixel_count_n = pixel_count;
            line_done_n = 1'b0;
            frame_done_n = 1'b0;
            line_error_n = 1'b0;
`ifdef LINESCANNER_TIMEOUT_EN
            timeout_n = 1'b0;
`endif
        end
    end

    always_ff @(posedge main_clock_source) begin
        if (!n_reset) begin
            state <= IDLE;
            line_index <= '0;
            pixel_count <= '0;
            scanner_enable <= 1'b0;
            busy <= 1'b0;
            line_done <= 1'b0;
            frame_done <= 1'b0;
            line_error <= 1'b0;
        end else begin
            state <= state_n;
            line_index <= line_index_n;
            pixel_count <= pixel_count_n;
            scanner_enable <= state_n == ARM;
            busy <= state_n != IDLE;
            line_done <= line_done_n;
            frame_done <= frame_done_n;
            line_error <= line_error_n;
        end
    end

`ifdef LINESCANNER_TIMEOUT_EN
    always_ff @(posedge main_clock_source) begin
        if (!n_reset)
            timeout_error <= 1'b0;
        else
            timeout_error <= timeout_n;
    end
`else
    assign timeout_error = 1'b0;
`endif
endmodule

// File: tb/tb_linescanner_frame_controller.sv
// tb_linescanner_frame_controller: directed scenarios with hand-computed expectations.
module tb_linescanner_frame_controller;
    logic main_clock_source = 1'b0;
    logic n_reset = 1'b0, start = 1'b0, abort = 1'b0, lval = 1'b0;
    logic scanner_enable, busy, line_done, frame_done, line_error, timeout_error;
    logic [15:0] line_index, pixel_count;

    linescanner_frame_controller #(
        .PIXELS_PER_LINE(4), .LINES_PER_FRAME(2), .LINE_PERIOD_CLKS(20), .TIMEOUT_CLKS(16)
    ) dut (
        .main_clock_source(main_clock_source), .n_reset(n_reset), .start(start),
        .abort(abort), .lval(lval), .scanner_enable(scanner_enable), .busy(busy),
        .line_index(line_index), .pixel_count(pixel_count), .line_done(line_done),
        .frame_done(frame_done), .line_error(line_error), .timeout_error(timeout_error)
    );

    always #5 main_clock_source = ~main_clock_source;

    int cyc = 0;
    always @(posedge main_clock_source) cyc <= cyc + 1;

    int n_ld = 0, n_le = 0, n_fd = 0, n_to = 0;
    always @(negedge main_clock_source) begin
        if (line_done) n_ld++;
        if (line_error) n_le++;
        if (frame_done) n_fd++;
        if (timeout_error) n_to++;
    end

    int n_checks = 0, n_pass = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge main_clock_source);
        #1;
    endtask

    task automatic begin_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_line(input int n);
        lval = 1'b1;
        repeat (n) tick();
        lval = 1'b0;
        tick();
    endtask

    task automatic wait_arm(input int max);
        for (int i = 0; i < max && !scanner_enable; i++) tick();
    endtask

    int a0, a1, ld0, le0, fd0, to0;

    initial begin
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_en", scanner_enable, 0);
        check("rst_line", line_index, 0);
        check("rst_pix", pixel_count, 0);
        check("rst_pulses", {line_done, frame_done, line_error, timeout_error}, 0);
        n_reset = 1'b1;
        tick();

        // nominal frame
        ld0 = n_ld; le0 = n_le; fd0 = n_fd; to0 = n_to;
        begin_frame();
        a0 = cyc;
        check("nom_en", scanner_enable, 1);
        check("nom_busy", busy, 1);
        check("nom_line0", line_index, 0);
        run_line(4);
        check("nom_ld0", line_done, 1);
        check("nom_le0", line_error, 0);
        check("nom_pix0", pixel_count, 4);
        check("nom_en_gap", scanner_enable, 0);
        wait_arm(40);
        a1 = cyc;
        check("nom_rearm", scanner_enable, 1);
        check("nom_period", a1 - a0, 20);
        check("nom_line1", line_index, 1);
        run_line(4);
        check("nom_ld1", line_done, 1);
        tick();
        check("nom_fd", frame_done, 1);
        check("nom_idle", busy, 0);
        check("nom_hold_line", line_index, 1);
        check("nom_hold_pix", pixel_count, 4);
        tick();
        check("nom_fd_width", frame_done, 0);
        check("nom_ld_cnt", n_ld - ld0, 2);
        check("nom_le_cnt", n_le - le0, 0);
        check("nom_fd_cnt", n_fd - fd0, 1);
        check("nom_to_cnt", n_to - to0, 0);

        // short line 0
        begin_frame();
        run_line(3);
        check("short_ld", line_done, 1);
        check("short_le", line_error, 1);
        check("short_pix", pixel_count, 3);
        tick();
        check("short_le_width", line_error, 0);
        wait_arm(40);
        check("short_line1", line_index, 1);
        run_line(4);
        check("short_le1", line_error, 0);
        tick();
        check("short_fd", frame_done, 1);
        tick();

        // long line rearms immediately, then abort in ACTIVE of line 1
        begin_frame();
        run_line(30);
        check("long_le", line_error, 1);
        check("long_pix", pixel_count, 30);
        tick();
        check("long_rearm", scanner_enable, 1);
        check("long_line1", line_index, 1);
        lval = 1'b1;
        repeat (2) tick();
        check("abort_pre_pix", pixel_count, 2);
        abort = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_en", scanner_enable, 0);
        check("abort_pix", pixel_count, 2);
        check("abort_line", line_index, 1);
        abort = 1'b0;
        lval = 1'b0;
        fd0 = n_fd;
        repeat (3) tick();
        check("abort_no_fd", n_fd - fd0, 0);

        // ARM dwell
        begin_frame();
        repeat (15) tick();
        check("dwell_en", scanner_enable, 1);
        tick();
`ifdef LINESCANNER_TIMEOUT_EN
        check("to_pulse", timeout_error, 1);
        check("to_busy", busy, 0);
        check("to_en", scanner_enable, 0);
        tick();
        check("to_width", timeout_error, 0);
`else
        check("noto_en", scanner_enable, 1);
        check("noto_busy", busy, 1);
        check("noto_pulse", timeout_error, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("noto_abort", busy, 0);
`endif

        // start while busy is ignored
        begin_frame();
        start = 1'b1;
        run_line(4);
        wait_arm(40);
        check("busy_start_line", line_index, 1);
        run_line(4);
        start = 1'b0;
        tick();
        check("busy_start_fd", frame_done, 1);
        repeat (2) tick();
        check("busy_start_noq", busy, 0);
        check("busy_start_en", scanner_enable, 0);

        // reset during GAP
        begin_frame();
        run_line(4);
        check("rgap_pix_pre", pixel_count, 4);
        n_reset = 1'b0;
        tick();
        check("rgap_busy", busy, 0);
        check("rgap_pix", pixel_count, 0);
        check("rgap_ld", line_done, 0);
        check("rgap_en", scanner_enable, 0);
        n_reset = 1'b1;
        repeat (25) tick();
        check("rgap_stay_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
